// File: rtl/baccarat_multihand_fsm.sv
// Multi-hand baccarat sequencer: deals NUM_HANDS player hands plus the dealer, applies third-card rules, latches lights.
// Optional per-hand saturating win tallies are built when BACCARAT_TALLY_EN is defined.
module baccarat_multihand_fsm #(
  parameter int NUM_HANDS = 2
) (
  input  logic                   slow_clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NUM_HANDS-1:0] pscore,
  input  logic [4*NUM_HANDS-1:0] pcard3,
  input  logic [3:0]             dscore,
  output logic [NUM_HANDS-1:0]   load_pcard1,
  output logic [NUM_HANDS-1:0]   load_pcard2,
  output logic [NUM_HANDS-1:0]   load_pcard3,
  output logic                   load_dcard1,
  output logic                   load_dcard2,
  output logic                   load_dcard3,
  output logic [NUM_HANDS-1:0]   player_win_light,
  output logic [NUM_HANDS-1:0]   dealer_win_light,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_HANDS-1:0] hand_wins
);

  typedef enum logic [3:0] {
    S_IDLE, S_DP1, S_DD1, S_DP2, S_DD2, S_EVAL, S_DP3, S_DEC, S_DD3, S_SETTLE, S_RESULT
  } state_t;

  localparam logic [1:0] LAST = 2'(NUM_HANDS - 1);

  state_t state, next_state;
  logic [1:0] idx, next_idx;
  logic [NUM_HANDS-1:0] mask, next_mask;
  logic nat0, next_nat0;

  logic [NUM_HANDS-1:0] nat, draw, pwin, dwin, sel;
  logic [1:0] first_set, next_set;
  logic more_set, dnat, dealer_draw, drew0;
  logic [3:0] p3_0;
  logic unused_pcard3;

  assign unused_pcard3 = ^pcard3;
  assign p3_0  = pcard3[3:0];
  assign drew0 = mask[0];
  assign dnat  = (dscore >= 4'd8);

  // Per-hand score classification; loops run high-to-low so the last hit is the lowest/next set bit.
  always_comb begin
    nat       = '0;
    draw      = '0;
    pwin      = '0;
    dwin      = '0;
    first_set = '0;
    next_set  = '0;
    more_set  = 1'b0;
    for (int i = NUM_HANDS - 1; i >= 0; i--) begin
      nat[i]  = (pscore[4*i +: 4] >= 4'd8);
      draw[i] = !nat[i] && (pscore[4*i +: 4] <= 4'd5);
      pwin[i] = (pscore[4*i +: 4] >= dscore);
      dwin[i] = (pscore[4*i +: 4] <= dscore);
      if (draw[i]) first_set = 2'(i);
      if (mask[i] && (2'(i) > idx)) begin
        next_set = 2'(i);
        more_set = 1'b1;
      end
    end
  end

  always_comb begin
    dealer_draw = !nat0 && (
        (!drew0 && dscore <= 4'd5) ||
        ( drew0 && dscore <= 4'd2) ||
        (dscore == 4'd3 && p3_0 != 4'd8) ||
        (dscore == 4'd4 && p3_0 >= 4'd2 && p3_0 <= 4'd7) ||
        (dscore == 4'd5 && p3_0 >= 4'd4 && p3_0 <= 4'd7) ||
        (dscore == 4'd6 && p3_0 >= 4'd6 && p3_0 <= 4'd7));
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_mask  = mask;
    next_nat0  = nat0;
    case (state)
      S_IDLE, S_RESULT: if (start) begin
        next_state = S_DP1;
        next_idx   = '0;
      end
      S_DP1: if (idx == LAST) begin
        next_state = S_DD1;
        next_idx   = '0;
      end else next_idx = idx + 2'd1;
      S_DD1: begin
        next_state = S_DP2;
        next_idx   = '0;
      end
      S_DP2: if (idx == LAST) begin
        next_state = S_DD2;
        next_idx   = '0;
      end else next_idx = idx + 2'd1;
      S_DD2: next_state = S_EVAL;
      S_EVAL: begin
        next_nat0 = nat[0];
        if (dnat) begin
          next_mask  = '0;
          next_state = S_SETTLE;
        end else begin
          next_mask = draw;
          if (|draw) begin
            next_state = S_DP3;
            next_idx   = first_set;
          end else next_state = S_DEC;
        end
      end
      S_DP3: if (more_set) next_idx = next_set;
             else next_state = S_DEC;
      S_DEC: next_state = dealer_draw ? S_DD3 : S_SETTLE;
      S_DD3: next_state = S_SETTLE;
      S_SETTLE: next_state = S_RESULT;
      default: next_state = S_IDLE;
    endcase
  end

  assign sel = NUM_HANDS'(1) << next_idx;

  // Outputs are registered from the next state so each strobe lines up with its state cycle.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      mask             <= '0;
      nat0             <= 1'b0;
      load_pcard1      <= '0;
      load_pcard2      <= '0;
      load_pcard3      <= '0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= '0;
      dealer_win_light <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state       <= next_state;
      idx         <= next_idx;
      mask        <= next_mask;
      nat0        <= next_nat0;
      load_pcard1 <= (next_state == S_DP1) ? sel : '0;
      load_pcard2 <= (next_state == S_DP2) ? sel : '0;
      load_pcard3 <= (next_state == S_DP3) ? sel : '0;
      load_dcard1 <= (next_state == S_DD1);
      load_dcard2 <= (next_state == S_DD2);
      load_dcard3 <= (next_state == S_DD3);
      busy        <= (next_state != S_IDLE) && (next_state != S_RESULT);
      done        <= (next_state == S_RESULT);
      if (state == S_SETTLE) begin
        player_win_light <= pwin;
        dealer_win_light <= dwin;
      end else if (state == S_RESULT && start) begin
        player_win_light <= '0;
        dealer_win_light <= '0;
      end
    end
  end

`ifdef BACCARAT_TALLY_EN
  logic [7:0] wins [NUM_HANDS];

  // A hand counts as won only when its player light is set alone.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_HANDS; i++) wins[i] <= '0;
    end else if (state == S_SETTLE) begin
      for (int i = 0; i < NUM_HANDS; i++)
        if (pwin[i] && !dwin[i] && wins[i] != 8'hFF) wins[i] <= wins[i] + 8'd1;
    end
  end

  always_comb begin
    hand_wins = '0;
    for (int i = 0; i < NUM_HANDS; i++) hand_wins[8*i +: 8] = wins[i];
  end
`else
  assign hand_wins = '0;
`endif

endmodule

// File: tb/tb_baccarat_multihand_fsm.sv
// Directed bench for baccarat_multihand_fsm with NUM_HANDS=2 and a behavioural card/score datapath.
// Tally checks are compiled when BACCARAT_TALLY_EN is defined.
module tb_baccarat_multihand_fsm;

  logic slow_clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] pscore, pcard3;
  logic [3:0] dscore;
  logic [1:0] load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic [1:0] player_win_light, dealer_win_light;
  logic busy, done;
  logic [15:0] hand_wins;

  int checks = 0;
  int errors = 0;
  int onehot_viol = 0;

  baccarat_multihand_fsm #(.NUM_HANDS(2)) dut (
    .slow_clock(slow_clock), .reset(reset), .start(start),
    .pscore(pscore), .pcard3(pcard3), .dscore(dscore),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .busy(busy), .done(done), .hand_wins(hand_wins)
  );

  always #5 slow_clock = ~slow_clock;

  // Datapath model: cards to be dealt, and cards actually loaded.
  logic [3:0] cur_p1 [2], cur_p2 [2], cur_p3 [2];
  logic [3:0] cur_d1, cur_d2, cur_d3;
  logic [3:0] pc1 [2] = '{4'd0, 4'd0};
  logic [3:0] pc2 [2] = '{4'd0, 4'd0};
  logic [3:0] pc3 [2] = '{4'd0, 4'd0};
  logic [3:0] dc1 = 4'd0, dc2 = 4'd0, dc3 = 4'd0;

  always @(posedge slow_clock) begin
    for (int i = 0; i < 2; i++) begin
      if (load_pcard1[i]) begin
        pc1[i] <= cur_p1[i];
        pc2[i] <= 4'd0;
        pc3[i] <= 4'd0;
      end
      if (load_pcard2[i]) pc2[i] <= cur_p2[i];
      if (load_pcard3[i]) pc3[i] <= cur_p3[i];
    end
    if (load_dcard1) begin
      dc1 <= cur_d1;
      dc2 <= 4'd0;
      dc3 <= 4'd0;
    end
    if (load_dcard2) dc2 <= cur_d2;
    if (load_dcard3) dc3 <= cur_d3;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pscore[4*i +: 4] = 4'((int'(pc1[i]) + int'(pc2[i]) + int'(pc3[i])) % 10);
      pcard3[4*i +: 4] = pc3[i];
    end
    dscore = 4'((int'(dc1) + int'(dc2) + int'(dc3)) % 10);
  end

  always @(negedge slow_clock) begin
    if ($countones({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3}) > 1)
      onehot_viol++;
  end

  typedef struct {
    logic [3:0] h0c1, h0c2, h0c3, h1c1, h1c2, h1c3, d1, d2, d3;
    logic [1:0] exp_p3;
    int         exp_dd;
    int         exp_d3cyc;
    int         exp_len;
    logic [1:0] exp_pl, exp_dl;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int v);
    cur_p1[0] = vecs[v].h0c1; cur_p2[0] = vecs[v].h0c2; cur_p3[0] = vecs[v].h0c3;
    cur_p1[1] = vecs[v].h1c1; cur_p2[1] = vecs[v].h1c2; cur_p3[1] = vecs[v].h1c3;
    cur_d1 = vecs[v].d1; cur_d2 = vecs[v].d2; cur_d3 = vecs[v].d3;
  endtask

  // Sample index cyc means the state entered at the cyc-th edge after the start edge.
  task automatic play_game(input int v, input int hold, input bit verbose);
    logic [1:0] p3_seen = '0;
    int dd_cnt = 0, d3_cyc = -1, done_cyc = -1;
    @(negedge slow_clock);
    apply_stimulus(v);
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge slow_clock);
      if (cyc >= hold) start = 1'b0;
      if (cyc == 0 && verbose)
        check_output($sformatf("v%0d_first_cycle", v), {28'd0, busy, done, player_win_light | dealer_win_light}, 32'h8);
      p3_seen |= load_pcard3;
      if (load_dcard3) begin
        dd_cnt++;
        d3_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check_output($sformatf("v%0d_done_timeout", v), 32'd0, 32'd1);
    if (verbose) begin
      check_output($sformatf("v%0d_pcard3_mask", v), p3_seen, vecs[v].exp_p3);
      check_output($sformatf("v%0d_dcard3_count", v), dd_cnt, vecs[v].exp_dd);
      if (vecs[v].exp_dd != 0) check_output($sformatf("v%0d_dcard3_cycle", v), d3_cyc, vecs[v].exp_d3cyc);
      check_output($sformatf("v%0d_game_length", v), done_cyc, vecs[v].exp_len);
      check_output($sformatf("v%0d_player_lights", v), player_win_light, vecs[v].exp_pl);
      check_output($sformatf("v%0d_dealer_lights", v), dealer_win_light, vecs[v].exp_dl);
    end
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    reset = 1'b1;
    repeat (2) @(negedge slow_clock);
    reset = 1'b0;
  endtask

  initial begin
    int quiet_bad;
    //             h0 c1 c2 c3        h1 c1 c2 c3        d c1 c2 c3       p3    dd d3cyc len pl     dl
    vecs[0] = '{4'd2,4'd2,4'd0, 4'd1,4'd3,4'd0, 4'd4,4'd5,4'd0, 2'b00, 0, 0,  8, 2'b00, 2'b11};
    vecs[1] = '{4'd2,4'd3,4'd8, 4'd3,4'd4,4'd0, 4'd1,4'd2,4'd5, 2'b01, 0, 0, 10, 2'b11, 2'b01};
    vecs[2] = '{4'd1,4'd1,4'd6, 4'd3,4'd3,4'd0, 4'd2,4'd4,4'd3, 2'b01, 1, 9, 11, 2'b00, 2'b11};
    vecs[3] = '{4'd4,4'd4,4'd0, 4'd1,4'd2,4'd4, 4'd1,4'd1,4'd5, 2'b10, 0, 0, 10, 2'b11, 2'b00};
    vecs[4] = '{4'd3,4'd3,4'd0, 4'd0,4'd7,4'd0, 4'd3,4'd4,4'd0, 2'b00, 0, 0,  9, 2'b10, 2'b11};
    vecs[5] = '{4'd2,4'd4,4'd0, 4'd5,4'd5,4'd9, 4'd2,4'd3,4'd2, 2'b10, 1, 9, 11, 2'b10, 2'b01};
    vecs[6] = '{4'd0,4'd1,4'd3, 4'd2,4'd2,4'd1, 4'd1,4'd3,4'd4, 2'b11, 1, 10, 12, 2'b00, 2'b11};
    vecs[7] = '{4'd2,4'd3,4'd0, 4'd4,4'd5,4'd0, 4'd3,4'd5,4'd0, 2'b00, 0, 0,  8, 2'b10, 2'b01};
    apply_stimulus(0);

    repeat (3) @(negedge slow_clock);
    check_output("reset_state", {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                 load_dcard3, player_win_light, dealer_win_light, busy, done, hand_wins}, 32'd0);
    reset = 1'b0;

    // Abort a game mid-DP2 with a 3-cycle reset.
    @(negedge slow_clock);
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    repeat (3) @(negedge slow_clock);
    check_output("mid_dp2_strobe", load_pcard2, 2'b01);
    reset = 1'b1;
    @(negedge slow_clock);
    check_output("reset_mid_game", {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                 load_dcard3, player_win_light, dealer_win_light, busy, done, hand_wins}, 32'd0);
    repeat (2) @(negedge slow_clock);
    reset = 1'b0;
    quiet_bad = 0;
    repeat (6) begin
      @(negedge slow_clock);
      if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3, busy, done} != '0)
        quiet_bad++;
    end
    check_output("idle_after_reset", quiet_bad, 0);

    for (int v = 0; v < 8; v++) play_game(v, 1, 1'b1);

    // start held through DP1 must not disturb the game.
    play_game(1, 2, 1'b1);
    check_output("strobe_onehot", onehot_viol, 0);

`ifdef BACCARAT_TALLY_EN
    do_reset();
    check_output("tally_cleared", hand_wins, 16'd0);
    play_game(4, 1, 1'b0);
    check_output("tally_loss_tie", hand_wins, 16'd0);
    play_game(3, 1, 1'b0);
    check_output("tally_one_win", hand_wins, 16'h0101);
    for (int g = 0; g < 255; g++) play_game(3, 1, 1'b0);
    check_output("tally_saturate", hand_wins, 16'hFFFF);
`else
    check_output("tally_disabled", hand_wins, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baccarat_multihand_fsm.md
Name: baccarat_multihand_fsm

Overview:
Parametrised successor to the single-player baccarat controller. It sequences one dealer hand against NUM_HANDS player hands and issues one card-load strobe per slow_clock cycle to the existing card/score datapath. It applies full third-card rules and latches per-hand win/lose/tie lights. Games start on a start pulse instead of auto-dealing.

Parameters:
NUM_HANDS, 2, number of player hands (1..4); hand 0 is the lead hand used for dealer third-card decisions.

Ports:
slow_clock  in  1  game clock; all state changes on posedge.
reset  in  1  synchronous, active-high.
start  in  1  begin a game; sampled only in IDLE or RESULT.
pscore  in  4*NUM_HANDS  hand i score at [4i+3:4i], 0..9, from datapath.
pcard3  in  4*NUM_HANDS  hand i third-card value, 0..9.
dscore  in  4  dealer score, 0..9.
load_pcard1/2/3  out  NUM_HANDS each  one-hot load strobes, bit i = hand i.
load_dcard1/2/3  out  1 each  dealer load strobes.
player_win_light  out  NUM_HANDS  hand i won; both lights set means tie.
dealer_win_light  out  NUM_HANDS  dealer beat or tied hand i.
busy  out  1  game in progress (not IDLE, not RESULT).
done  out  1  high throughout RESULT.
hand_wins  out  8*NUM_HANDS  per-hand saturating win tallies (see Optional Feature).

Behaviour:
- Reset: state IDLE, hand index 0, masks cleared, all outputs 0. Reset has priority in every state and aborts a game mid-deal; no strobe is issued in the reset cycle or the cycle after.
- Registered Moore outputs. Every strobe is high for exactly one cycle. At most one strobe of all load_* is high in any cycle.
- Datapath contract: score/card inputs reflect a load one cycle after its strobe cycle.
- States and transitions:
  - IDLE: start=1 -> DP1 with idx=0.
  - DP1: load_pcard1[idx] high. idx++ per cycle; after idx=NUM_HANDS-1 -> DD1.
  - DD1: load_dcard1 high -> DP2 with idx=0.
  - DP2: load_pcard2[idx] high, iterating as in DP1 -> DD2.
  - DD2: load_dcard2 high -> EVAL.
  - EVAL (no strobe): compute nat[i] = pscore_i in {8,9}; dnat = dscore in {8,9}.
    - If dnat: draw mask = 0 -> SETTLE.
    - Else draw[i] = !nat[i] && pscore_i <= 5.
    - If mask nonzero -> DP3 at its lowest set bit; else -> DEC.
  - DP3: load_pcard3[idx] high. Jump to the next set bit; unset hands cost no cycles. After the last set bit -> DEC.
  - DEC (no strobe; pcard3 now valid): dealer draws iff !dnat && !nat[0] and one of:
    - hand 0 stood and dscore <= 5;
    - hand 0 drew and dscore 0..2;
    - dscore=3 and pcard3_0 != 8;
    - dscore=4 and pcard3_0 in 2..7;
    - dscore=5 and pcard3_0 in 4..7;
    - dscore=6 and pcard3_0 in 6..7.
    Draw -> DD3; else -> SETTLE.
  - DD3: load_dcard3 high -> SETTLE.
  - SETTLE (no strobe): per hand, latch lights for the final scores:
    - pscore_i > dscore: player light only;
    - pscore_i < dscore: dealer light only;
    - equal: both lights.
    -> RESULT.
  - RESULT: lights held, done=1. start=1 clears lights and goes to DP1 in the same edge; no IDLE visit.
- start is ignored while busy. Inputs outside 0..9 are undefined and need not be handled.
- Game length: 2*NUM_HANDS+2 deal cycles, plus 1 (EVAL), plus popcount(draw mask), plus 1 (DEC, skipped when dnat), plus 1 if the dealer draws, plus 1 (SETTLE).

Optional Feature:
Macro BACCARAT_TALLY_EN.
- Defined: on entry to RESULT, each hand_wins byte increments when that hand won (player light only). Counters saturate at 255. Ties and losses leave them unchanged. Only reset clears them.
- Not defined: hand_wins is constant 0 and no counter registers are generated.

Test Plan:
- NUM_HANDS=2, reset high 3 cycles mid-DP2 -> all outputs 0 next cycle; IDLE held until start; no strobe after reset.
- Both hands score 4 after two cards, dscore=9 -> no load_pcard3/load_dcard3. Lights: player=00, dealer=11. done asserted 8 cycles after start.
- Hand 0=5 with pcard3=8 (final 3), hand 1=7, dscore=3 -> load_pcard3=01 only; dealer stands (3 vs 8). Final 3/7 vs 3 -> hand 0 tie (both lights), hand 1 player win.
- Hand 0=2 with pcard3=6, dscore=6 -> load_dcard3 pulses once, exactly 1 cycle after DEC.
- Hand 0=8 natural, hand 1=3, dscore=2 -> load_pcard3=10; dealer does not draw (lead natural).
- BACCARAT_TALLY_EN: 256 games with hand 0 always winning -> hand_wins[7:0] reads 255, not 0. start during DP1 has no effect.
